// File: rtl/tx_burst_gen_if.sv
// Handshake and drive bundle between the transmit controller and the burst generator.
// master = controller side (drives enTx), slave = burst generator side.
interface tx_burst_gen_if #(
    parameter int CNT_W = 16
);
    logic             enTx;
    logic             tx_p;
    logic             tx_n;
    logic             tx_active;
    logic             overTx;
    logic [CNT_W-1:0] burst_cnt;

    modport master (
        output enTx,
        input  tx_p, tx_n, tx_active, overTx, burst_cnt
    );

    modport slave (
        input  enTx,
        output tx_p, tx_n, tx_active, overTx, burst_cnt
    );
endinterface

// File: rtl/tx_burst_gen.sv
// Transmit burst generator: settle delay, NUM_PULSES complementary periods on tx_p/tx_n,
// ring-down delay, then overTx held until the controller drops enTx.
module tx_burst_gen #(
    parameter int HALF_PERIOD = 25,
    parameter int NUM_PULSES  = 8,
    parameter int PRE_DELAY   = 100,
    parameter int POST_DELAY  = 1000,
    parameter int CNT_W       = 16
) (
    input  logic         clk_100,
    input  logic         rst,
    tx_burst_gen_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_BURST = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_DELAY - 1);
    localparam logic [CNT_W-1:0] POST_LOAD = CNT_W'(POST_DELAY - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(NUM_PULSES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             half_q, half_d;      // 0 = phase A (tx_p), 1 = phase B (tx_n)
    logic             tx_p_q, tx_p_d;
    logic             tx_n_q, tx_n_d;
    logic             tx_active_q, tx_active_d;
    logic             over_tx_q, over_tx_d;

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dly_q       <= ZERO;
            phase_q     <= ZERO;
            period_q    <= ZERO;
            burst_cnt_q <= ZERO;
            half_q      <= 1'b0;
            tx_p_q      <= 1'b0;
            tx_n_q      <= 1'b0;
            tx_active_q <= 1'b0;
            over_tx_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            phase_q     <= phase_d;
            period_q    <= period_d;
            burst_cnt_q <= burst_cnt_d;
            half_q      <= half_d;
            tx_p_q      <= tx_p_d;
            tx_n_q      <= tx_n_d;
            tx_active_q <= tx_active_d;
            over_tx_q   <= over_tx_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they land registered.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        phase_d     = phase_q;
        period_d    = period_q;
        burst_cnt_d = burst_cnt_q;
        half_d      = half_q;

        case (state_q)
            S_IDLE: begin
                if (bus.enTx) begin
                    state_d = S_PRE;
                    dly_d   = PRE_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                if (!bus.enTx) begin
                    state_d = S_IDLE;
                end else if (dly_q == ZERO) begin
                    state_d  = S_BURST;
                    phase_d  = ZERO;
                    period_d = ZERO;
                    half_d   = 1'b0;
                end else begin
                    dly_d = dly_q - ONE;
                end
            end
            S_BURST: begin
                if (!bus.enTx) begin
                    state_d = S_IDLE;
                end else if (phase_q != HALF_LAST) begin
                    phase_d = phase_q + ONE;
                end else begin
                    phase_d = ZERO;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else if (period_q == PER_LAST) begin
                        state_d = S_POST;
                        half_d  = 1'b0;
                        dly_d   = POST_LOAD;
                    end else begin
                        half_d   = 1'b0;
                        period_d = period_q + ONE;
                    end
                end
            end
            S_POST: begin
                if (!bus.enTx) begin
                    state_d = S_IDLE;
                end else if (dly_q == ZERO) begin
                    state_d     = S_DONE;
                    burst_cnt_d = burst_cnt_q + ONE;
                end else begin
                    dly_d = dly_q - ONE;
                end
            end
            S_DONE: begin
                if (!bus.enTx) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                dly_d    = ZERO;
                phase_d  = ZERO;
                period_d = ZERO;
                half_d   = 1'b0;
            end
        endcase

        tx_p_d      = (state_d == S_BURST) && !half_d;
        tx_n_d      = (state_d == S_BURST) && half_d;
        tx_active_d = (state_d == S_PRE) || (state_d == S_BURST) || (state_d == S_POST);
        over_tx_d   = (state_d == S_DONE);
    end

    assign bus.tx_p      = tx_p_q;
    assign bus.tx_n      = tx_n_q;
    assign bus.tx_active = tx_active_q;
    assign bus.overTx    = over_tx_q;
    assign bus.burst_cnt = burst_cnt_q;
endmodule
